// File: rtl/wb_packer.sv
// wb_packer: packs 16-bit results into BURST_LEN-word lines, queues them, issues data-then-command bursts (last word t -> wr_en t+2 -> cmd_en t+3).
// Backpressure from wr_full/cmd_ready holds the head line; stall warns one line early. Define WB_STALL_CNT_EN to enable the stall_cycles counter.
module wb_packer #(
    parameter int BURST_LEN = 8,
    parameter int ADDR_W    = 30,
    parameter int DEPTH     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ADDR_W-1:0]      base_addr,
    input  logic                   ib_valid,
    input  logic [15:0]            ib_data,
    input  logic                   flush,
    output logic                   stall,
    output logic                   wr_en,
    output logic [16*BURST_LEN-1:0] wr_data,
    output logic [2*BURST_LEN-1:0] wr_mask,
    input  logic                   wr_full,
    output logic                   cmd_en,
    output logic [ADDR_W-1:0]      cmd_addr,
    output logic [5:0]             cmd_bl,
    input  logic                   cmd_ready,
    output logic                   flush_done,
    output logic                   idle,
    output logic                   err_ovf,
    output logic [31:0]            stall_cycles
);

    localparam int IW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int PW = $clog2(DEPTH);
    localparam int LW = 16 * BURST_LEN;
    localparam int MW = 2 * BURST_LEN;
    localparam logic [IW-1:0]     IDX_LAST   = IW'(BURST_LEN - 1);
    localparam logic [PW:0]       CNT_FULL   = (PW + 1)'(DEPTH);
    localparam logic [PW:0]       CNT_HI     = (PW + 1)'(DEPTH - 1);
    localparam logic [PW:0]       CNT_MID    = (PW + 1)'(DEPTH - 2);
    localparam logic [ADDR_W-1:0] LINE_BYTES = ADDR_W'(2 * BURST_LEN);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_CMD} state_t;

    state_t             state_q, state_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [LW-1:0]      line_q, line_d, line_cur;
    logic [IW:0]        n_words;
    logic               full_line, part_line, push_now, push_ok, pop;
    logic [MW-1:0]      push_msk;
    logic [LW-1:0]      dat_mem_q [DEPTH];
    logic [LW-1:0]      dat_mem_d [DEPTH];
    logic [MW-1:0]      msk_mem_q [DEPTH];
    logic [MW-1:0]      msk_mem_d [DEPTH];
    logic [PW-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PW:0]        cnt_q, cnt_d;
    logic               fifo_empty, fifo_full;
    logic [ADDR_W-1:0]  base_q, base_d;
    logic [23:0]        line_cnt_q, line_cnt_d;
    logic               flush_pend_q, flush_pend_d;
    logic               err_ovf_q, err_ovf_d;
    logic               start_ok;

    // Words above the pack index are always zero because the line register clears on every push.
    always_comb begin
        line_cur = line_q;
        if (ib_valid) begin
            line_cur[16*int'(idx_q) +: 16] = ib_data;
        end
        n_words   = {1'b0, idx_q} + {{IW{1'b0}}, ib_valid};
        full_line = ib_valid && (idx_q == IDX_LAST);
        part_line = flush && !full_line && (n_words != '0);
        push_now  = full_line || part_line;
        for (int k = 0; k < BURST_LEN; k++) begin
            push_msk[2*k +: 2] = (k < int'(n_words)) ? 2'b00 : 2'b11;
        end
        if (push_now) begin
            idx_d  = '0;
            line_d = '0;
        end else begin
            idx_d  = ib_valid ? idx_q + 1'b1 : idx_q;
            line_d = line_cur;
        end
    end

    always_comb begin
        fifo_empty = (cnt_q == '0);
        fifo_full  = (cnt_q == CNT_FULL);
        push_ok    = push_now && !fifo_full;
        pop        = (state_q == S_CMD) && cmd_ready;
        dat_mem_d  = dat_mem_q;
        msk_mem_d  = msk_mem_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        cnt_d      = cnt_q;
        if (push_ok) begin
            dat_mem_d[wptr_q] = line_cur;
            msk_mem_d[wptr_q] = push_msk;
            wptr_d            = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        case ({push_ok, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        err_ovf_d = err_ovf_q || (push_now && fifo_full);
    end

    always_comb begin
        idle         = (idx_q == '0) && fifo_empty && (state_q == S_IDLE);
        start_ok     = start && idle;
        base_d       = start_ok ? base_addr : base_q;
        line_cnt_d   = start_ok ? '0 : (pop ? line_cnt_q + 24'd1 : line_cnt_q);
        flush_done   = flush_pend_q && fifo_empty && (state_q == S_IDLE);
        flush_pend_d = flush || (flush_pend_q && !flush_done);
        // The extra line of headroom absorbs one word already in flight from the engine.
        stall        = (cnt_q >= CNT_HI) || ((cnt_q == CNT_MID) && push_now);
    end

    always_comb begin
        state_d = state_q;
        wr_en   = 1'b0;
        cmd_en  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (!wr_full) begin
                    wr_en   = 1'b1;
                    state_d = S_CMD;
                end
            end
            S_CMD: begin
                cmd_en = 1'b1;
                if (cmd_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign wr_data  = wr_en ? dat_mem_q[rptr_q] : '0;
    assign wr_mask  = wr_en ? msk_mem_q[rptr_q] : '0;
    assign cmd_addr = cmd_en ? base_q + ADDR_W'(line_cnt_q) * LINE_BYTES : '0;
    assign cmd_bl   = 6'(BURST_LEN - 1);
    assign err_ovf  = err_ovf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            line_q       <= '0;
            dat_mem_q    <= '{default: '0};
            msk_mem_q    <= '{default: '0};
            wptr_q       <= '0;
            rptr_q       <= '0;
            cnt_q        <= '0;
            base_q       <= '0;
            line_cnt_q   <= '0;
            flush_pend_q <= 1'b0;
            err_ovf_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            line_q       <= line_d;
            dat_mem_q    <= dat_mem_d;
            msk_mem_q    <= msk_mem_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            cnt_q        <= cnt_d;
            base_q       <= base_d;
            line_cnt_q   <= line_cnt_d;
            flush_pend_q <= flush_pend_d;
            err_ovf_q    <= err_ovf_d;
        end
    end

`ifdef WB_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic        stall_evt;

    always_comb begin
        stall_evt   = (cmd_en && !cmd_ready) || ((state_q == S_DATA) && wr_full);
        stall_cnt_d = stall_cnt_q;
        if (start_ok) begin
            stall_cnt_d = '0;
        end else if (stall_evt && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_wb_packer.sv
// Self-checking bench for wb_packer: queue-based line model, randomized words and backpressure.
module tb_wb_packer;
    localparam int BL = 8;
    localparam int AW = 30;

    logic          clk = 1'b0;
    logic          rst, start, ib_valid, flush, wr_full, cmd_ready;
    logic [AW-1:0] base_addr;
    logic [15:0]   ib_data;
    logic          stall, wr_en, cmd_en, flush_done, idle, err_ovf;
    logic [127:0]  wr_data;
    logic [15:0]   wr_mask;
    logic [AW-1:0] cmd_addr;
    logic [5:0]    cmd_bl;
    logic [31:0]   stall_cycles;

    always #5 clk = ~clk;

    wb_packer #(.BURST_LEN(BL), .ADDR_W(AW), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .ib_valid(ib_valid), .ib_data(ib_data), .flush(flush), .stall(stall),
        .wr_en(wr_en), .wr_data(wr_data), .wr_mask(wr_mask), .wr_full(wr_full),
        .cmd_en(cmd_en), .cmd_addr(cmd_addr), .cmd_bl(cmd_bl), .cmd_ready(cmd_ready),
        .flush_done(flush_done), .idle(idle), .err_ovf(err_ovf), .stall_cycles(stall_cycles)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;

    // Reference model: pending words, expected lines and expected burst addresses.
    logic [15:0]   m_words[$];
    logic [127:0]  exp_dat[$];
    logic [15:0]   exp_msk[$];
    logic [AW-1:0] exp_addr[$];
    logic [AW-1:0] m_base;
    int            m_line;

    int wr_cnt, acc_cnt, fd_cnt, first_wr, first_cmd, mon_stall;
    logic pend, stall_last, rnd_bp, hold_mode;
    logic [AW-1:0] pend_addr;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic m_emit();
        logic [127:0] d;
        logic [15:0]  m;
        d = '0;
        m = 16'hFFFF;
        foreach (m_words[i]) d[16*i +: 16] = m_words[i];
        m = m << (2 * m_words.size());
        exp_dat.push_back(d);
        exp_msk.push_back(m);
        exp_addr.push_back(m_base + AW'(m_line * 16));
        m_line++;
        m_words.delete();
    endtask

    task automatic mon();
        if (wr_full) chk("wr_en_while_full", wr_en, 0);
        if (wr_en) begin
            wr_cnt++;
            if (first_wr < 0) first_wr = cyc;
            if (exp_dat.size() == 0) begin
                chk("unexpected_wr", wr_en, 0);
            end else begin
                chk("wr_data", wr_data, exp_dat.pop_front());
                chk("wr_mask", wr_mask, exp_msk.pop_front());
            end
        end
        if (pend) begin
            chk("cmd_en_held", cmd_en, 1);
            chk("cmd_addr_held", cmd_addr, pend_addr);
        end
        if (cmd_en) begin
            if (first_cmd < 0) first_cmd = cyc;
            chk("cmd_bl", cmd_bl, BL - 1);
            if (!cmd_ready) mon_stall++;
        end
        if (cmd_en && cmd_ready) begin
            acc_cnt++;
            if (exp_addr.size() == 0) chk("unexpected_cmd", cmd_en, 0);
            else chk("cmd_addr", cmd_addr, exp_addr.pop_front());
        end
        pend = cmd_en && !cmd_ready;
        pend_addr = cmd_addr;
        if (flush_done) fd_cnt++;
        stall_last = stall;
    endtask

    task automatic tick();
        @(negedge clk);
        mon();
        @(posedge clk);
        cyc++;
        #1;
        if (rnd_bp) begin
            cmd_ready = ($urandom_range(0, 9) < 7);
            wr_full   = ($urandom_range(0, 9) < 2);
        end
        if (hold_mode && mon_stall >= 10) begin
            cmd_ready = 1'b1;
            hold_mode = 1'b0;
        end
    endtask

    task automatic send_word(input logic [15:0] d, input logic fl, input logic st);
        ib_valid = 1'b1;
        ib_data  = d;
        flush    = fl;
        start    = st;
        if (st && m_words.size() == 0 && exp_addr.size() == 0) begin
            m_base = base_addr;
            m_line = 0;
        end
        m_words.push_back(d);
        if (m_words.size() == BL || fl) m_emit();
        tick();
        ib_valid = 1'b0;
        flush    = 1'b0;
        start    = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        if (m_words.size() > 0) m_emit();
        tick();
        flush = 1'b0;
    endtask

    task automatic do_start(input logic [AW-1:0] b);
        base_addr = b;
        start     = 1'b1;
        m_base    = b;
        m_line    = 0;
        tick();
        start = 1'b0;
    endtask

    task automatic drain(input int maxc);
        int i;
        i = 0;
        while (!(idle === 1'b1 && exp_dat.size() == 0 && exp_addr.size() == 0) && i < maxc) begin
            tick();
            i++;
        end
        chk("drain_idle", idle, 1);
        chk("drain_left", exp_dat.size() + exp_addr.size(), 0);
        tick();
        tick();
    endtask

    task automatic chk_reset();
        chk("rst_idle", idle, 1);
        chk("rst_stall", stall, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_wr_mask", wr_mask, 0);
        chk("rst_cmd_en", cmd_en, 0);
        chk("rst_cmd_addr", cmd_addr, 0);
        chk("rst_cmd_bl", cmd_bl, BL - 1);
        chk("rst_flush_done", flush_done, 0);
        chk("rst_err_ovf", err_ovf, 0);
        chk("rst_stall_cycles", stall_cycles, 0);
    endtask

    initial begin
        int t_last, fd0, w0, a0, g, n;
        logic [AW-1:0] b;
        rst = 1'b1; start = 1'b0; base_addr = '0; ib_valid = 1'b0; ib_data = '0;
        flush = 1'b0; wr_full = 1'b0; cmd_ready = 1'b1;
        rnd_bp = 1'b0; hold_mode = 1'b0; pend = 1'b0; stall_last = 1'b0;
        wr_cnt = 0; acc_cnt = 0; fd_cnt = 0; first_wr = -1; first_cmd = -1; mon_stall = 0;
        m_base = '0; m_line = 0;
        repeat (3) tick();
        chk_reset();
        rst = 1'b0;
        tick();

        // One full line with start coincident with the first word; latency check.
        base_addr = 30'h100;
        first_wr = -1; first_cmd = -1; w0 = wr_cnt;
        send_word(16'h0001, 1'b0, 1'b1);
        t_last = 0;
        for (int i = 2; i <= 8; i++) begin
            if (i == 8) t_last = cyc;
            send_word(16'(i), 1'b0, 1'b0);
        end
        drain(100);
        chk("lat_wr", first_wr, t_last + 2);
        chk("lat_cmd", first_cmd, t_last + 3);
        chk("t1_wr_count", wr_cnt - w0, 1);

        // 11 words + flush on the last; a busy start in the middle is ignored.
        do_start(30'h100);
        fd0 = fd_cnt;
        for (int i = 0; i < 11; i++) begin
            if (i == 3) base_addr = 30'h999;
            send_word(16'h0011 + 16'(i), i == 10, i == 3);
        end
        drain(100);
        chk("t2_flush_done", fd_cnt - fd0, 1);

        // Flush with nothing packed.
        fd0 = fd_cnt; w0 = wr_cnt; a0 = acc_cnt;
        do_flush();
        drain(50);
        chk("t3_flush_done", fd_cnt - fd0, 1);
        chk("t3_no_wr", wr_cnt - w0, 0);
        chk("t3_no_cmd", acc_cnt - a0, 0);

        // Four lines with the command port blocked; stall appears at three queued.
        do_start(30'h2000);
        cmd_ready = 1'b0;
        for (int i = 0; i < 32; i++) begin
            send_word(16'($urandom), 1'b0, 1'b0);
            if (i == 7)  chk("stall_1q", stall, 0);
            if (i == 23) chk("stall_3q", stall, 1);
        end
        chk("t4_err_ovf", err_ovf, 0);
        cmd_ready = 1'b1;
        drain(200);

        // Exactly ten blocked command cycles on one line.
        do_start(30'h3000);
        mon_stall = 0;
        cmd_ready = 1'b0;
        hold_mode = 1'b1;
        for (int i = 0; i < 8; i++) send_word(16'($urandom), 1'b0, 1'b0);
        drain(200);
`ifdef WB_STALL_CNT_EN
        chk("stall_cycles", stall_cycles, 10);
`else
        chk("stall_cycles", stall_cycles, 0);
`endif

        // Write-data port full for five cycles while a line waits.
        wr_full = 1'b1;
        for (int i = 0; i < 8; i++) send_word(16'h5000 + 16'(i), 1'b0, 1'b0);
        repeat (6) tick();
        wr_full = 1'b0;
        drain(100);
        chk("t5_err_ovf", err_ovf, 0);

        // Randomized words, gaps and backpressure; one run wraps the address.
        for (int it = 0; it < 3; it++) begin
            b = (it == 1) ? 30'h3FFF_FFF0 : 30'($urandom);
            n = $urandom_range(40, 90);
            do_start(b);
            fd0 = fd_cnt;
            rnd_bp = 1'b1;
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 3) == 0) tick();
                g = 0;
                while (stall_last && g < 200) begin tick(); g++; end
                send_word(16'($urandom), 1'b0, 1'b0);
            end
            g = 0;
            while (stall_last && g < 200) begin tick(); g++; end
            do_flush();
            rnd_bp = 1'b0; cmd_ready = 1'b1; wr_full = 1'b0;
            drain(500);
            chk("rnd_flush_done", fd_cnt - fd0, 1);
            chk("rnd_err_ovf", err_ovf, 0);
        end

        // Overflow by ignoring stall, then reset mid-burst.
        do_start(30'h400);
        cmd_ready = 1'b0;
        for (int i = 0; i < 40; i++) send_word(16'($urandom), 1'b0, 1'b0);
        chk("ovf_flag", err_ovf, 1);
        rst = 1'b1;
        #2;
        chk_reset();
        m_words.delete(); exp_dat.delete(); exp_msk.delete(); exp_addr.delete();
        pend = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        cmd_ready = 1'b1;
        w0 = wr_cnt; a0 = acc_cnt;
        repeat (20) tick();
        chk("post_rst_wr", wr_cnt - w0, 0);
        chk("post_rst_cmd", acc_cnt - a0, 0);
        chk("post_rst_idle", idle, 1);
        chk("post_rst_ovf", err_ovf, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end
endmodule
